// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry and the write-back request bundle.
package cpu_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned DATA_W = 32;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic              en;
        logic [REG_AW-1:0] wr_reg;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_late_fifo.sv
// Circular queue of late write-back results with per-entry kill-by-register and a
// busy mask of registers that still have a live queued write.
module wb_late_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [REG_AW-1:0]          push_reg,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    input  logic                       kill_en,
    input  logic [REG_AW-1:0]          kill_reg,
    output logic                       head_valid,
    output logic [REG_AW-1:0]          head_reg,
    output logic [DATA_W-1:0]          head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [(2**REG_AW)-1:0]     busy_mask
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [REG_AW-1:0] reg_q  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]  count_q;

    // Kill is applied before push so an entry accepted alongside the younger pipe write survives.
    always_comb begin
        valid_d = valid_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (kill_en && (reg_q[i] == kill_reg)) begin
                valid_d[i] = 1'b0;
            end
        end
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
        end
        if (push) begin
            valid_d[wr_ptr_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            valid_q <= valid_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            reg_q[wr_ptr_q]  <= push_reg;
            data_q[wr_ptr_q] <= push_data;
        end
    end

    // Freed slots always have valid cleared, so only live entries contribute.
    always_comb begin
        busy_mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) begin
                busy_mask[reg_q[i]] = 1'b1;
            end
        end
    end

    assign head_valid = valid_q[rd_ptr_q];
    assign head_reg   = reg_q[rd_ptr_q];
    assign head_data  = data_q[rd_ptr_q];
    assign empty      = (count_q == '0);
    assign full       = (count_q == CNT_W'(DEPTH));
    assign count      = count_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write port arbiter: WB-stage writes win, queued late results fill the gaps.
// The output bundle uses cpu_pkg::wb_req_t, so DATA_W/REG_AW follow the package values.
module regfile_wb_arbiter #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = cpu_pkg::DATA_W,
    parameter int unsigned REG_AW = cpu_pkg::REG_AW
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pipe_wr_en,
    input  logic [REG_AW-1:0]          pipe_wr_reg,
    input  logic [DATA_W-1:0]          pipe_wr_data,
    input  logic                       late_valid,
    output logic                       late_ready,
    input  logic [REG_AW-1:0]          late_reg,
    input  logic [DATA_W-1:0]          late_data,
    output logic                       RegWrite,
    output logic [REG_AW-1:0]          Write_register,
    output logic [DATA_W-1:0]          Write_data,
    output logic [(2**REG_AW)-1:0]     busy_mask,
    output logic [$clog2(DEPTH+1)-1:0] q_count
);

    import cpu_pkg::*;

    logic              pipe_take;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              head_valid;
    logic [REG_AW-1:0] head_reg;
    logic [DATA_W-1:0] head_data;
    wb_req_t           wb_q, wb_d;

    assign pipe_take  = pipe_wr_en && (pipe_wr_reg != REG_ZERO);
    assign late_ready = !reset && !fifo_full;
    // A late result for r0 completes the handshake but is dropped.
    assign push       = late_valid && late_ready && (late_reg != REG_ZERO);
    assign pop        = !pipe_take && !fifo_empty;

    wb_late_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_late_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_reg   (late_reg),
        .push_data  (late_data),
        .pop        (pop),
        .kill_en    (pipe_take),
        .kill_reg   (pipe_wr_reg),
        .head_valid (head_valid),
        .head_reg   (head_reg),
        .head_data  (head_data),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (q_count),
        .busy_mask  (busy_mask)
    );

    // Idle cycles hold index/data; a killed head still updates them but with en low.
    always_comb begin
        wb_d    = wb_q;
        wb_d.en = 1'b0;
        if (pipe_take) begin
            wb_d.en     = 1'b1;
            wb_d.wr_reg = pipe_wr_reg;
            wb_d.data   = pipe_wr_data;
        end else if (pop) begin
            wb_d.en     = head_valid;
            wb_d.wr_reg = head_reg;
            wb_d.data   = head_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_q <= '0;
        end else begin
            wb_q <= wb_d;
        end
    end

    assign RegWrite       = wb_q.en;
    assign Write_register = wb_q.wr_reg;
    assign Write_data     = wb_q.data;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios with literal expectations, then random
// traffic checked every cycle against a queue-based behavioural model.
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        pipe_wr_en;
    logic [4:0]  pipe_wr_reg;
    logic [31:0] pipe_wr_data;
    logic        late_valid;
    logic        late_ready;
    logic [4:0]  late_reg;
    logic [31:0] late_data;
    logic        RegWrite;
    logic [4:0]  Write_register;
    logic [31:0] Write_data;
    logic [31:0] busy_mask;
    logic [2:0]  q_count;

    regfile_wb_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .pipe_wr_en     (pipe_wr_en),
        .pipe_wr_reg    (pipe_wr_reg),
        .pipe_wr_data   (pipe_wr_data),
        .late_valid     (late_valid),
        .late_ready     (late_ready),
        .late_reg       (late_reg),
        .late_data      (late_data),
        .RegWrite       (RegWrite),
        .Write_register (Write_register),
        .Write_data     (Write_data),
        .busy_mask      (busy_mask),
        .q_count        (q_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: FIFO of pending writes, registered write-port outputs, regfile image.
    typedef struct {
        bit        v;
        bit [4:0]  r;
        bit [31:0] d;
    } ent_t;

    ent_t      mq[$];
    bit        m_rw;
    bit [4:0]  m_wr;
    bit [31:0] m_wd;
    bit [31:0] m_rf[32];

    int n_chk  = 0;
    int n_pass = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit [31:0] m_busy();
        bit [31:0] b = '0;
        foreach (mq[i]) begin
            if (mq[i].v) b[mq[i].r] = 1'b1;
        end
        return b;
    endfunction

    task automatic model_step();
        bit   acc;
        ent_t e;
        if (reset) begin
            mq.delete();
            m_rw = 1'b0;
            m_wr = '0;
            m_wd = '0;
        end else begin
            acc = late_valid && (mq.size() < DEPTH);
            if (pipe_wr_en && pipe_wr_reg != 5'd0) begin
                foreach (mq[i]) begin
                    if (mq[i].r == pipe_wr_reg) mq[i].v = 1'b0;
                end
                m_rw = 1'b1;
                m_wr = pipe_wr_reg;
                m_wd = pipe_wr_data;
            end else if (mq.size() > 0) begin
                e    = mq.pop_front();
                m_rw = e.v;
                m_wr = e.r;
                m_wd = e.d;
            end else begin
                m_rw = 1'b0;
            end
            if (acc && late_reg != 5'd0) begin
                e.v = 1'b1;
                e.r = late_reg;
                e.d = late_data;
                mq.push_back(e);
            end
            if (m_rw) m_rf[m_wr] = m_wd;
        end
    endtask

    // Advance one clock; leaves the caller just after the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("RegWrite", RegWrite, m_rw);
            chk("Write_register", Write_register, m_wr);
            chk("Write_data", Write_data, m_wd);
            chk("busy_mask", busy_mask, m_busy());
            chk("q_count", q_count, mq.size());
            chk("late_ready", late_ready, !reset && (mq.size() < DEPTH));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p;
        reset        = 1'b1;
        pipe_wr_en   = 1'b0;
        pipe_wr_reg  = '0;
        pipe_wr_data = '0;
        late_valid   = 1'b1;
        late_reg     = 5'd7;
        late_data    = 32'h7777;
        foreach (m_rf[i]) m_rf[i] = '0;

        // 1. Reset held two cycles with late_valid high.
        tick();
        cmp_en = 1'b1;
        tick();
        chk("rst late_ready", late_ready, 1'b0);
        chk("rst RegWrite", RegWrite, 1'b0);
        chk("rst busy_mask", busy_mask, 32'h0);
        chk("rst q_count", q_count, 3'd0);
        reset      = 1'b0;
        late_valid = 1'b0;

        // 2. Pipe only, then a write to r0.
        pipe_wr_en   = 1'b1;
        pipe_wr_reg  = 5'd8;
        pipe_wr_data = 32'h1234;
        tick();
        chk("pipe RegWrite", RegWrite, 1'b1);
        chk("pipe Write_register", Write_register, 5'd8);
        chk("pipe Write_data", Write_data, 32'h1234);
        pipe_wr_reg = 5'd0;
        tick();
        chk("pipe r0 RegWrite", RegWrite, 1'b0);

        // 3. Late path with the pipe idle.
        pipe_wr_en = 1'b0;
        late_valid = 1'b1;
        late_reg   = 5'd5;
        late_data  = 32'hCAFE;
        tick();
        late_valid = 1'b0;
        chk("late busy5 t+1", busy_mask[5], 1'b1);
        chk("late RegWrite t+1", RegWrite, 1'b0);
        tick();
        chk("late RegWrite t+2", RegWrite, 1'b1);
        chk("late Write_register t+2", Write_register, 5'd5);
        chk("late Write_data t+2", Write_data, 32'hCAFE);
        tick();
        chk("late busy5 t+3", busy_mask[5], 1'b0);

        // 4. Fill under continuous pipe writes, then drain in order.
        pipe_wr_en  = 1'b1;
        pipe_wr_reg = 5'd1;
        late_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            pipe_wr_data = k;
            late_reg     = 5'(10 + k);
            late_data    = 32'hA0 + k;
            tick();
        end
        late_reg = 5'd20;
        tick();
        chk("full q_count", q_count, 3'd4);
        chk("full late_ready", late_ready, 1'b0);
        chk("full busy_mask", busy_mask, 32'h0000_3C00);
        pipe_wr_en = 1'b0;
        late_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("drain RegWrite", RegWrite, 1'b1);
            chk("drain Write_register", Write_register, 5'(10 + k));
            chk("drain Write_data", Write_data, 32'hA0 + k);
            if (k == 0) chk("drain late_ready", late_ready, 1'b1);
        end

        // 5. WAW kill of a queued reg 9 by a younger pipe write.
        late_valid   = 1'b1;
        late_reg     = 5'd9;
        late_data    = 32'h99;
        pipe_wr_en   = 1'b1;
        pipe_wr_reg  = 5'd2;
        pipe_wr_data = 32'h22;
        tick();
        chk("waw busy9 queued", busy_mask[9], 1'b1);
        late_valid   = 1'b0;
        pipe_wr_reg  = 5'd9;
        pipe_wr_data = 32'h1;
        tick();
        chk("waw busy9 killed", busy_mask[9], 1'b0);
        chk("waw pipe Write_data", Write_data, 32'h1);
        chk("waw q_count", q_count, 3'd1);
        pipe_wr_en = 1'b0;
        tick();
        chk("waw killed pop RegWrite", RegWrite, 1'b0);
        chk("waw q_count drained", q_count, 3'd0);
        chk("waw model rf9", m_rf[9], 32'h1);

        // 6. Reset in the middle of a drain.
        pipe_wr_en  = 1'b1;
        pipe_wr_reg = 5'd1;
        late_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            late_reg  = (k == 2) ? 5'd6 : 5'(3 + k);
            late_data = 32'h300 + k;
            tick();
        end
        chk("pre-reset q_count", q_count, 3'd3);
        pipe_wr_en = 1'b0;
        late_valid = 1'b0;
        reset      = 1'b1;
        tick();
        chk("mid-reset q_count", q_count, 3'd0);
        chk("mid-reset busy_mask", busy_mask, 32'h0);
        chk("mid-reset RegWrite", RegWrite, 1'b0);
        chk("mid-reset late_ready", late_ready, 1'b0);
        reset = 1'b0;
        tick();
        chk("post-reset RegWrite", RegWrite, 1'b0);
        tick();
        chk("post-reset RegWrite 2", RegWrite, 1'b0);
        chk("post-reset q_count", q_count, 3'd0);

        // Random traffic in phases of differing pipe pressure.
        for (int c = 0; c < 3000; c++) begin
            case ((c / 400) % 3)
                0:       p = 20;
                1:       p = 50;
                default: p = 85;
            endcase
            reset        = ($urandom_range(0, 149) == 0);
            pipe_wr_en   = ($urandom_range(0, 99) < p);
            pipe_wr_reg  = 5'($urandom_range(0, 7));
            pipe_wr_data = $urandom;
            late_valid   = ($urandom_range(0, 99) < 60);
            late_reg     = 5'($urandom_range(0, 7));
            late_data    = $urandom;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
